// File: rtl/mux_4_1_rr_arbiter.sv
// rtl/mux_4_1_rr_arbiter.sv - 4:1 data mux with burst-granular round-robin arbitration
// Optional MUX_4_1_ARB_FIXED_PRIO_EN: fixed lowest-index-wins priority instead of round-robin.
module mux_4_1_rr_arbiter #(
    parameter int WIDTH    = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req,
    input  logic [3:0]       last,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_sel,
    output logic [3:0]       gnt
);

    localparam int CW = $clog2(MAX_HOLD + 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t         r_state, w_state_nxt;
    logic [1:0]     r_sel, w_sel_nxt;
    logic [CW-1:0]  r_cnt, w_cnt_nxt;
    logic [WIDTH-1:0] w_mux;
    logic           w_xfer;
    logic           w_end_beat;
    logic [3:0]     w_others;
    logic [3:0]     w_cand;

`ifdef MUX_4_1_ARB_FIXED_PRIO_EN
    // Lowest set index wins; the loop runs high-to-low so the last hit is index 0.
    function automatic logic [1:0] f_pick(input logic [3:0] r);
        logic [1:0] w;
        w = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (r[i]) w = 2'(i);
        end
        return w;
    endfunction
`else
    logic [1:0]     r_ptr, w_ptr_nxt;

    // Search ptr+1 .. ptr+4; iterating backwards lets the nearest candidate win.
    function automatic logic [1:0] f_pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] w;
        logic [1:0] idx;
        w = 2'd0;
        for (int k = 4; k >= 1; k--) begin
            idx = p + 2'(k);
            if (r[idx]) w = idx;
        end
        return w;
    endfunction
`endif

    always_comb begin
        case (r_sel)
            2'd0:    w_mux = d0;
            2'd1:    w_mux = d1;
            2'd2:    w_mux = d2;
            default: w_mux = d3;
        endcase
    end

    always_comb begin
        out_valid   = 1'b0;
        out_data    = '0;
        gnt         = 4'b0000;
        w_xfer      = 1'b0;
        w_end_beat  = 1'b0;
        w_others    = req & ~(4'b0001 << r_sel);
        w_cand      = req;
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_cnt_nxt   = r_cnt;
`ifndef MUX_4_1_ARB_FIXED_PRIO_EN
        w_ptr_nxt   = r_ptr;
`endif
        case (r_state)
            IDLE: begin
                if (req != 4'b0000) begin
                    w_state_nxt = BUSY;
                    w_cnt_nxt   = '0;
`ifdef MUX_4_1_ARB_FIXED_PRIO_EN
                    w_sel_nxt   = f_pick(req);
`else
                    w_sel_nxt   = f_pick(req, r_ptr);
                    w_ptr_nxt   = w_sel_nxt;
`endif
                end
            end
            default: begin
                out_valid  = req[r_sel];
                out_data   = out_valid ? w_mux : '0;
                w_xfer     = out_valid & out_ready;
                gnt        = w_xfer ? (4'b0001 << r_sel) : 4'b0000;
                w_end_beat = w_xfer & (last[r_sel] | (r_cnt == HOLD_LAST));
                if (w_end_beat || !req[r_sel]) begin
`ifndef MUX_4_1_ARB_FIXED_PRIO_EN
                    // A finishing owner yields only if someone else is waiting.
                    if (w_end_beat && w_others != 4'b0000) w_cand = w_others;
`endif
                    if (w_cand != 4'b0000) begin
                        w_cnt_nxt = '0;
`ifdef MUX_4_1_ARB_FIXED_PRIO_EN
                        w_sel_nxt = f_pick(w_cand);
`else
                        w_sel_nxt = f_pick(w_cand, r_sel);
                        w_ptr_nxt = w_sel_nxt;
`endif
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else if (w_xfer) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_sel   <= 2'd0;
            r_cnt   <= '0;
`ifndef MUX_4_1_ARB_FIXED_PRIO_EN
            r_ptr   <= 2'd3;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_cnt   <= w_cnt_nxt;
`ifndef MUX_4_1_ARB_FIXED_PRIO_EN
            r_ptr   <= w_ptr_nxt;
`endif
        end
    end

    assign out_sel = r_sel;

endmodule

// File: tb/tb_mux_4_1_rr_arbiter.sv
// tb/tb_mux_4_1_rr_arbiter.sv - randomized bench for mux_4_1_rr_arbiter against a behavioural model
module tb_mux_4_1_rr_arbiter;

    localparam int WIDTH    = 4;
    localparam int MAX_HOLD = 8;

    logic             clk;
    logic             rst;
    logic [3:0]       req;
    logic [3:0]       last;
    logic [WIDTH-1:0] d [4];
    logic             out_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       out_sel;
    logic [3:0]       gnt;

    int n_checks;
    int n_errors;

    // Behavioural model: who owns the channel, beats taken, last winner.
    bit m_busy;
    int m_sel;
    int m_cnt;
    int m_ptr;
    logic [3:0] seen_gnt;

    mux_4_1_rr_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .last      (last),
        .d0        (d[0]),
        .d1        (d[1]),
        .d2        (d[2]),
        .d3        (d[3]),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .gnt       (gnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int m_pick(input logic [3:0] r, input int p);
`ifdef MUX_4_1_ARB_FIXED_PRIO_EN
        for (int i = 0; i < 4; i++) if (r[i]) return i;
`else
        for (int k = 1; k <= 4; k++) if (r[(p + k) % 4]) return (p + k) % 4;
`endif
        return -1;
    endfunction

    task automatic model_reset();
        m_busy = 1'b0;
        m_sel  = 0;
        m_cnt  = 0;
        m_ptr  = 3;
    endtask

    task automatic check_and_step(input string tag);
        logic             ev;
        logic             xfer;
        logic             endab;
        logic [WIDTH-1:0] ed;
        logic [3:0]       eg;
        logic [3:0]       cand;
        logic [3:0]       others;
        int               w;
        ev   = m_busy && req[m_sel];
        ed   = ev ? d[m_sel] : '0;
        xfer = ev && out_ready;
        eg   = xfer ? 4'(1 << m_sel) : 4'b0000;
        check({tag, ".valid"}, 32'(out_valid), 32'(ev));
        check({tag, ".data"},  32'(out_data),  32'(ed));
        check({tag, ".sel"},   32'(out_sel),   32'(m_sel));
        check({tag, ".gnt"},   32'(gnt),       32'(eg));
        seen_gnt = gnt;
        if (!m_busy) begin
            if (req != 4'b0000) begin
                w      = m_pick(req, m_ptr);
                m_busy = 1'b1;
                m_sel  = w;
                m_ptr  = w;
                m_cnt  = 0;
            end
        end else begin
            endab = xfer && (last[m_sel] || m_cnt == MAX_HOLD - 1);
            if (endab || !req[m_sel]) begin
                cand   = req;
                others = req & ~4'(1 << m_sel);
`ifndef MUX_4_1_ARB_FIXED_PRIO_EN
                if (endab && others != 4'b0000) cand = others;
`endif
                w = m_pick(cand, m_sel);
                if (w < 0) begin
                    m_busy = 1'b0;
                end else begin
                    m_sel = w;
                    m_ptr = w;
                    m_cnt = 0;
                end
            end else if (xfer) begin
                m_cnt++;
            end
        end
    endtask

    task automatic cycle(input string tag);
        @(negedge clk);
        check_and_step(tag);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int run;
        int best;
        int n2;
        n_checks  = 0;
        n_errors  = 0;
        seen_gnt  = 4'b0000;
        rst       = 1'b1;
        req       = 4'hF;
        last      = 4'h0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) d[i] = 4'(i + 5);
        model_reset();
        #12;
        check("rst.valid", 32'(out_valid), 32'd0);
        check("rst.data",  32'(out_data),  32'd0);
        check("rst.gnt",   32'(gnt),       32'd0);
        check("rst.sel",   32'(out_sel),   32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        req = 4'h0;
        cycle("idle");

        // Single requester, 3-beat bursts back to back.
        req  = 4'b0100;
        d[2] = 4'hA;
        n2   = 0;
        for (int c = 0; c < 8; c++) begin
            last = ((c % 3) == 0 && c > 0) ? 4'b0100 : 4'b0000;
            cycle("single");
            if (seen_gnt == 4'b0100) n2++;
        end
        check("single.beats", 32'(n2), 32'd7);

        // Everyone requesting single-beat bursts.
        req  = 4'hF;
        last = 4'hF;
        for (int c = 0; c < 8; c++) cycle("rotate");

        // Port 1 never ends its burst; MAX_HOLD must force rotation.
        req  = 4'h0;
        last = 4'h0;
        cycle("drain");
        req  = 4'b0110;
        run  = 0;
        best = 0;
        for (int c = 0; c < 30; c++) begin
            cycle("hold");
            run  = (seen_gnt == 4'b0010) ? run + 1 : 0;
            best = (run > best) ? run : best;
        end
`ifdef MUX_4_1_ARB_FIXED_PRIO_EN
        check("hold.run", 32'(best), 32'd29);
`else
        check("hold.run", 32'(best), 32'(MAX_HOLD));
`endif

        // Back-pressure mid-burst.
        req = 4'b0001;
        for (int c = 0; c < 14; c++) begin
            out_ready = !(c >= 3 && c < 8);
            cycle("stall");
        end
        out_ready = 1'b1;

        // Reset in the middle of a burst.
        req = 4'b1000;
        for (int c = 0; c < 3; c++) cycle("preRst");
        #2;
        rst = 1'b1;
        #1;
        check("midrst.valid", 32'(out_valid), 32'd0);
        check("midrst.gnt",   32'(gnt),       32'd0);
        check("midrst.data",  32'(out_data),  32'd0);
        check("midrst.sel",   32'(out_sel),   32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Randomized traffic.
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(7) == 0) req[i] = ~req[i];
                last[i] = ($urandom_range(3) == 0);
                d[i]    = 4'($urandom);
            end
            out_ready = ($urandom_range(3) != 0);
            cycle("rand");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
